// File: rtl/mul_seq_pkg.sv
// Shared types and constants for the nibble-sequenced 8x8 multiplier.
// The step index selects which operand nibbles feed the 4x4 core and how far the partial product is shifted.
package mul_seq_pkg;

    localparam int W     = 8;
    localparam int CW    = 4;
    localparam int STEPS = 4;

    typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

    typedef logic [1:0] step_t;

    typedef struct packed {
        logic a_hi;
        logic b_hi;
    } nib_sel_t;

    // step0: lo*lo, step1: hi*lo, step2: lo*hi, step3: hi*hi
    function automatic nib_sel_t nib_sel(input step_t s);
        nib_sel_t r;
        r.a_hi = s[0];
        r.b_hi = s[1];
        return r;
    endfunction

    function automatic logic [3:0] step_shift(input step_t s);
        case (s)
            2'd0:    return 4'd0;
            2'd1:    return 4'd4;
            2'd2:    return 4'd4;
            default: return 4'd8;
        endcase
    endfunction

endpackage

// File: rtl/mul8_seq_ctrl_mul4_core.sv
// Combinational 4x4 unsigned array multiplier: AND-gate partial-product rows
// summed through ripple rows of full adders.
module mul4_core
    import mul_seq_pkg::*;
(
    input  logic [CW-1:0]   i_a,
    input  logic [CW-1:0]   i_b,
    output logic [2*CW-1:0] o_p
);

    always_comb begin
        logic [2*CW-1:0] sum;
        logic [2*CW-1:0] row;
        logic            c;
        logic            s;
        sum = '0;
        for (int i = 0; i < CW; i++) begin
            row = {{CW{1'b0}}, (i_a & {CW{i_b[i]}})} << i;
            c   = 1'b0;
            for (int k = 0; k < 2*CW; k++) begin
                s      = sum[k] ^ row[k] ^ c;
                c      = (sum[k] & row[k]) | (c & (sum[k] ^ row[k]));
                sum[k] = s;
            end
        end
        o_p = sum;
    end

endmodule

// File: rtl/mul8_seq_ctrl.sv
// 8x8 -> 16 unsigned multiplier built by time-sharing one 4x4 core over four steps,
// with valid/ready handshakes on operands and product.
module mul8_seq_ctrl
    import mul_seq_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*W-1:0] product,
    output logic           busy
);

    state_t         r_state;
    step_t          r_step;
    logic [2*W-1:0] r_acc;
    logic [W-1:0]   r_a;
    logic [W-1:0]   r_b;
    logic [2*W-1:0] r_prod;
    logic           r_out_valid;
    logic           r_in_ready;
    logic           r_busy;

    nib_sel_t       w_sel;
    logic [CW-1:0]  w_nib_a;
    logic [CW-1:0]  w_nib_b;
    logic [2*CW-1:0] w_pp;
    logic [2*W-1:0] w_acc_nxt;

    assign w_sel     = nib_sel(r_step);
    assign w_nib_a   = w_sel.a_hi ? r_a[W-1:CW] : r_a[CW-1:0];
    assign w_nib_b   = w_sel.b_hi ? r_b[W-1:CW] : r_b[CW-1:0];
    // Max sum is 0xFE01, so the 16-bit accumulator never carries out.
    assign w_acc_nxt = r_acc + ({{(2*W-2*CW){1'b0}}, w_pp} << step_shift(r_step));

    mul4_core u_core (
        .i_a (w_nib_a),
        .i_b (w_nib_b),
        .o_p (w_pp)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_step      <= '0;
            r_acc       <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_prod      <= '0;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a        <= a;
                        r_b        <= b;
                        r_acc      <= '0;
                        r_step     <= '0;
                        r_state    <= MUL;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                    end
                end
                MUL: begin
                    r_acc  <= w_acc_nxt;
                    r_step <= r_step + 2'd1;
                    if (r_step == step_t'(STEPS - 1)) begin
                        r_prod      <= w_acc_nxt;
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign product   = r_prod;
    assign busy      = r_busy;

endmodule
